// File: rtl/output_buffer_drain_if.sv
// Handshake bundle between the accumulator/host side and the result buffer.
// master drives accumulator writes and drain control; slave is the buffer.
interface output_buffer_drain_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] acc_data;
  logic [ADDR_W-1:0] acc_addr;
  logic              clear;
  logic              drain_start;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              full;
  logic              overwrite_err;

  modport master (
    output acc_data, acc_addr, clear, drain_start, out_ready,
    input  out_valid, out_data, out_addr, busy, full, overwrite_err
  );

  modport slave (
    input  acc_data, acc_addr, clear, drain_start, out_ready,
    output out_valid, out_data, out_addr, busy, full, overwrite_err
  );
endinterface

// File: rtl/output_buffer_drain.sv
// Addressed result buffer: captures accumulator writes into entries 1..DEPTH-1
// and drains valid entries in ascending address order over a valid/ready stream.
module output_buffer_drain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output_buffer_drain_if.slave   bus
);

  localparam int unsigned        DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                err_q, err_d;
  logic                wr;
  logic                hs;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_d       = mem_q;
    valid_d     = valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;
    wr          = (bus.acc_addr != '0);
    hs          = (state_q == PRESENT) && out_valid_q && bus.out_ready;

    if (bus.clear) begin
      valid_d     = '0;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = IDLE;
      ptr_d       = FIRST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.drain_start) begin
            ptr_d   = FIRST;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (valid_q[ptr_q]) begin
            out_data_d  = mem_q[ptr_q];
            out_addr_d  = ptr_q;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end else if (ptr_q == LAST) begin
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + FIRST;
          end
        end
        PRESENT: begin
          if (hs) begin
            out_valid_d    = 1'b0;
            valid_d[ptr_q] = 1'b0;
            if (ptr_q == LAST) begin
              state_d = IDLE;
            end else begin
              ptr_d   = ptr_q + FIRST;
              state_d = SCAN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Write applied last so it overrides both clear and the handshake's
    // valid-bit drop for its own entry; clear still wins for the error flag.
    if (wr) begin
      mem_d[bus.acc_addr]   = bus.acc_data;
      valid_d[bus.acc_addr] = 1'b1;
      if (valid_q[bus.acc_addr] && !(hs && (bus.acc_addr == ptr_q)) && !bus.clear) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= FIRST;
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_addr      = out_addr_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.full          = &valid_q[DEPTH-1:1];
  assign bus.overwrite_err = err_q;

endmodule

// File: tb/tb_output_buffer_drain.sv
// Directed and randomized checks of output_buffer_drain against an
// entry-level model of the buffer contents and the expected drain order.
module tb_output_buffer_drain;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bit          m_valid [16];
  logic [31:0] m_data  [16];
  bit          m_err;

  output_buffer_drain_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  output_buffer_drain #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 16; a++) m_valid[a] = 1'b0;
    m_err = 1'b0;
  endtask

  function automatic logic model_full();
    for (int a = 1; a < 16; a++) if (!m_valid[a]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.acc_addr = a;
    bus.acc_data = d;
    tick();
    bus.acc_addr = '0;
    if (a != 4'd0) begin
      if (m_valid[a]) m_err = 1'b1;
      m_valid[a] = 1'b1;
      m_data[a]  = d;
    end
  endtask

  // Full drain pass; ready asserted with probability pct percent each cycle.
  task automatic drain(input int unsigned pct);
    int unsigned  q_addr [$];
    logic [31:0]  q_data [$];
    int unsigned  exp_n;
    int unsigned  nw;
    logic         held;
    logic [3:0]   h_a;
    logic [31:0]  h_d;
    int           c;
    for (int a = 1; a < 16; a++) begin
      if (m_valid[a]) begin
        q_addr.push_back(a);
        q_data.push_back(m_data[a]);
      end
    end
    exp_n = q_addr.size();
    nw    = 0;
    held  = 1'b0;
    c     = 0;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    while (bus.busy && c < 400) begin
      if (held) begin
        chk("hold_addr", 32'(bus.out_addr), 32'(h_a));
        chk("hold_data", bus.out_data, h_d);
      end
      held = 1'b0;
      bus.out_ready = ($urandom_range(99) < pct);
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          nw++;
          if (q_addr.size() > 0) begin
            chk("drain_addr", 32'(bus.out_addr), q_addr.pop_front());
            chk("drain_data", bus.out_data, q_data.pop_front());
          end
        end else begin
          held = 1'b1;
          h_a  = bus.out_addr;
          h_d  = bus.out_data;
        end
      end
      tick();
      c++;
    end
    bus.out_ready = 1'b0;
    chk("drain_done_busy", 32'(bus.busy), 32'd0);
    chk("drain_done_valid", 32'(bus.out_valid), 32'd0);
    chk("word_count", nw, exp_n);
    for (int a = 0; a < 16; a++) m_valid[a] = 1'b0;
  endtask

  initial begin
    int n;
    int c;
    bit sawv;

    rst             = 1'b1;
    bus.acc_data    = '0;
    bus.acc_addr    = '0;
    bus.clear       = 1'b0;
    bus.drain_start = 1'b0;
    bus.out_ready   = 1'b0;
    model_clear();
    for (int a = 0; a < 16; a++) m_data[a] = '0;

    #8;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_err", 32'(bus.overwrite_err), 32'd0);
    #4 rst = 1'b0;
    tick();

    // Three sparse entries, always-ready sink
    wr(4'd3, 32'hA);
    wr(4'd7, 32'hB);
    wr(4'd15, 32'hC);
    drain(100);
    drain(100);

    // Stall on a single entry
    wr(4'd5, 32'h11);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 40) begin tick(); c++; end
    chk("stall_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_addr", 32'(bus.out_addr), 32'd5);
      chk("stall_data", bus.out_data, 32'h11);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall_xfer", 32'(bus.out_valid), 32'd0);
    c = 0;
    while (bus.busy && c < 40) begin
      chk("stall_no_more", 32'(bus.out_valid), 32'd0);
      tick();
      c++;
    end
    chk("stall_idle", 32'(bus.busy), 32'd0);
    m_valid[5] = 1'b0;

    // Address 0, full, overwrite, clear
    wr(4'd0, 32'hDEAD);
    drain(100);
    for (int a = 1; a < 16; a++) begin
      wr(4'(a), 32'(a * 3));
      if (a == 14) chk("full_at_14", 32'(bus.full), 32'd0);
    end
    chk("full_all", 32'(bus.full), 32'(model_full()));
    chk("no_err_yet", 32'(bus.overwrite_err), 32'(m_err));
    wr(4'd4, 32'h44);
    chk("overwrite_err", 32'(bus.overwrite_err), 32'(m_err));
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
    chk("clear_full", 32'(bus.full), 32'd0);
    chk("clear_err", 32'(bus.overwrite_err), 32'd0);

    // Write into the entry being presented
    wr(4'd2, 32'h1);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 40) begin tick(); c++; end
    chk("pres_addr", 32'(bus.out_addr), 32'd2);
    chk("pres_data", bus.out_data, 32'h1);
    bus.acc_addr  = 4'd2;
    bus.acc_data  = 32'h2;
    bus.out_ready = 1'b1;
    tick();
    bus.acc_addr  = '0;
    bus.out_ready = 1'b0;
    chk("pres_xfer", 32'(bus.out_valid), 32'd0);
    chk("pres_no_err", 32'(bus.overwrite_err), 32'd0);
    c = 0;
    while (bus.busy && c < 40) begin tick(); c++; end
    for (int a = 0; a < 16; a++) m_valid[a] = 1'b0;
    m_valid[2] = 1'b1;
    m_data[2]  = 32'h2;
    drain(100);

    // Latency and async reset mid-drain
    wr(4'd1, 32'h123);
    wr(4'd9, 32'h999);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    chk("lat_first", 32'(bus.out_valid), 32'd0);
    chk("lat_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("lat_second", 32'(bus.out_valid), 32'd1);
    chk("lat_addr", 32'(bus.out_addr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_data", bus.out_data, 32'd0);
    #4 rst = 1'b0;
    model_clear();
    tick();

    // Empty drain, with ignored restart pulses
    drain(100);
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    n    = 0;
    sawv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) n++;
      if (bus.out_valid) sawv = 1'b1;
      bus.drain_start = (i == 3 || i == 7);
      tick();
    end
    bus.drain_start = 1'b0;
    chk("empty_busy_cycles", 32'(n), 32'd15);
    chk("empty_no_valid", 32'(sawv), 32'd0);

    // Randomized rounds
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) wr(4'($urandom_range(15, 0)), $urandom);
      chk("rnd_full", 32'(bus.full), 32'(model_full()));
      chk("rnd_err", 32'(bus.overwrite_err), 32'(m_err));
      if ($urandom_range(3, 0) == 0) begin
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
        chk("rnd_clear_err", 32'(bus.overwrite_err), 32'd0);
      end
      drain($urandom_range(100, 30));
      chk("rnd_post_full", 32'(bus.full), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
